// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: stall, branch flush and EX operand forwarding
//
// Tracks the instructions in EX, MEM and WB and decides, each cycle, whether
// the instruction in ID must wait, which pipeline latches a taken branch
// squashes, and where the EX stage should take its operands from.
//
// Parameters
//   RA_W     register-address width (3..6)
//   FWD_EN   1 = forwarding mode, 0 = stall-only mode
//   BR_FLUSH younger latches squashed on a taken branch (1..3)
//   CNT_W    performance-counter width (8..32)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid                 ID slot holds a real instruction
//   id_rs, id_rt             ID source registers
//   id_use_rs, id_use_rt     ID instruction reads rs / rt
//   id_dst                   ID destination register
//   id_reg_write             ID instruction writes the register file
//   id_mem_read              ID instruction is a load
//   br_taken                 taken branch resolved this cycle
//   cnt_clr                  synchronous clear of both counters
//   stall                    hold PC and IF/ID, bubble into ID/EX
//   flush_mask               bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM squash
//   fwd_a, fwd_b             EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_cycles             saturating count of stalled cycles
//   flush_events             saturating count of taken branches
module pipe_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int FWD_EN   = 1,
  parameter int BR_FLUSH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             br_taken,
  input  logic             cnt_clr,
  output logic             stall,
  output logic [2:0]       flush_mask,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam bit FWD = (FWD_EN != 0);
  localparam logic [2:0] BR_MASK = (BR_FLUSH >= 3) ? 3'b111 :
                                   (BR_FLUSH == 2) ? 3'b011 : 3'b001;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // EX slot
  logic            ex_valid, ex_rw, ex_mr, ex_use_rs, ex_use_rt;
  logic [RA_W-1:0] ex_dst, ex_rs, ex_rt;
  // MEM slot
  logic            mem_valid, mem_rw, mem_mr;
  logic [RA_W-1:0] mem_dst;
  // WB slot
  logic            wb_valid, wb_rw, wb_mr;
  logic [RA_W-1:0] wb_dst;

  // The load flags of the older slots are tracked but no decision needs them.
  logic unused_trk;
  assign unused_trk = mem_mr ^ wb_mr;

  // A producer matches a consumer source only when it really writes a
  // non-zero register that the consumer really reads; r0 is never a hazard.
  function automatic logic prod_hit(input logic            v,
                                    input logic            rw,
                                    input logic [RA_W-1:0] dst,
                                    input logic [RA_W-1:0] src,
                                    input logic            src_used);
    return v & rw & src_used & (dst != '0) & (dst == src);
  endfunction

  // ID sources against the EX and MEM producers
  logic ex_hit_id, mem_hit_id, stall_raw;
  always_comb begin
    ex_hit_id  = prod_hit(ex_valid, ex_rw, ex_dst, id_rs, id_use_rs) |
                 prod_hit(ex_valid, ex_rw, ex_dst, id_rt, id_use_rt);
    mem_hit_id = prod_hit(mem_valid, mem_rw, mem_dst, id_rs, id_use_rs) |
                 prod_hit(mem_valid, mem_rw, mem_dst, id_rt, id_use_rt);
    // WB never stalls: the register file writes through to the read port.
    if (FWD)
      stall_raw = id_valid & ex_hit_id & ex_mr;
    else
      stall_raw = id_valid & (ex_hit_id | mem_hit_id);
  end

  // A taken branch kills the ID instruction anyway, so it overrides the stall.
  always_comb begin
    stall      = rst & ~br_taken & stall_raw;
    flush_mask = (rst & br_taken) ? BR_MASK : 3'b000;
  end

  // EX operands against the MEM and WB producers; the younger MEM wins.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD && ex_valid) begin
      if (prod_hit(mem_valid, mem_rw, mem_dst, ex_rs, ex_use_rs))
        fwd_a = 2'b10;
      else if (prod_hit(wb_valid, wb_rw, wb_dst, ex_rs, ex_use_rs))
        fwd_a = 2'b01;
      if (prod_hit(mem_valid, mem_rw, mem_dst, ex_rt, ex_use_rt))
        fwd_b = 2'b10;
      else if (prod_hit(wb_valid, wb_rw, wb_dst, ex_rt, ex_use_rt))
        fwd_b = 2'b01;
    end
  end

  // Tracker advance and performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_rw        <= 1'b0;
      ex_mr        <= 1'b0;
      ex_use_rs    <= 1'b0;
      ex_use_rt    <= 1'b0;
      ex_dst       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      mem_valid    <= 1'b0;
      mem_rw       <= 1'b0;
      mem_mr       <= 1'b0;
      mem_dst      <= '0;
      wb_valid     <= 1'b0;
      wb_rw        <= 1'b0;
      wb_mr        <= 1'b0;
      wb_dst       <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_rw     <= mem_rw;
      wb_mr     <= mem_mr;
      wb_dst    <= mem_dst;

      mem_valid <= ex_valid & ~flush_mask[2];
      mem_rw    <= ex_rw;
      mem_mr    <= ex_mr;
      mem_dst   <= ex_dst;

      ex_valid  <= id_valid & ~stall & ~flush_mask[1];
      ex_rw     <= id_reg_write;
      ex_mr     <= id_mem_read;
      ex_use_rs <= id_use_rs;
      ex_use_rt <= id_use_rt;
      ex_dst    <= id_dst;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;

      if (cnt_clr)
        stall_cycles <= '0;
      else if (stall && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_ONE;

      if (cnt_clr)
        flush_events <= '0;
      else if (br_taken && !(&flush_events))
        flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed table-driven bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       br_taken, cnt_clr;

  // a: forwarding, BR_FLUSH=2, 8-bit counters
  logic        a_stall;
  logic [2:0]  a_flush;
  logic [1:0]  a_fa, a_fb;
  logic [7:0]  a_sc, a_fe;
  // b: stall-only, BR_FLUSH=3, 16-bit counters
  logic        b_stall;
  logic [2:0]  b_flush;
  logic [1:0]  b_fa, b_fb;
  logic [15:0] b_sc, b_fe;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(1), .BR_FLUSH(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .br_taken(br_taken), .cnt_clr(cnt_clr), .stall(a_stall),
    .flush_mask(a_flush), .fwd_a(a_fa), .fwd_b(a_fb),
    .stall_cycles(a_sc), .flush_events(a_fe));

  pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(0), .BR_FLUSH(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .br_taken(br_taken), .cnt_clr(cnt_clr), .stall(b_stall),
    .flush_mask(b_flush), .fwd_a(b_fa), .fwd_b(b_fb),
    .stall_cycles(b_sc), .flush_events(b_fe));

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       rw, mr, br;
    logic       stall;
    logic [2:0] flush;
    logic [1:0] fa, fb;
    logic [7:0] sc, fe;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mkv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] dst,
                               input logic rw, input logic mr, input logic br,
                               input logic st, input logic [2:0] fl,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [7:0] sc, input logic [7:0] fe);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.dst = dst;
    r.rw = rw; r.mr = mr; r.br = br; r.stall = st; r.flush = fl;
    r.fa = fa; r.fb = fb; r.sc = sc; r.fe = fe;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br_taken = 1'b0;
    cnt_clr  = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  // Advance until dut_a stalls; a missing stall within the budget is a failure.
  task automatic wait_a_stall(input string name);
    bit seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_stall) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) chk({name, "_timeout"}, 32'(a_stall), 32'd1);
  endtask

  initial begin
    // v  rs  rt urs urt dst rw mr br | stall flush fa fb sc fe
    vecs[0]  = mkv(1,  1, 0, 1, 0,  8, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0); // lw r8
    vecs[1]  = mkv(1,  8, 2, 1, 1,  9, 1, 0, 0, 1, 3'b000, 2'b00, 2'b00, 0, 0); // add r9,r8,r2: load-use
    vecs[2]  = mkv(1,  8, 2, 1, 1,  9, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 0); // held, bubble in EX
    vecs[3]  = mkv(1,  1, 2, 1, 1,  3, 1, 0, 0, 0, 3'b000, 2'b01, 2'b00, 1, 0); // add in EX gets lw from WB
    vecs[4]  = mkv(1,  3, 3, 1, 1,  4, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 0); // sub r4,r3,r3
    vecs[5]  = mkv(1,  9, 1, 1, 1,  0, 1, 0, 0, 0, 3'b000, 2'b10, 2'b10, 1, 0); // sub in EX: both from MEM
    vecs[6]  = mkv(1,  0, 0, 1, 1,  5, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 0); // or r5,r0,r0
    vecs[7]  = mkv(1,  4, 0, 1, 0,  0, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 1, 0); // r0 producer in MEM: no fwd
    vecs[8]  = mkv(1,  0, 5, 1, 1,  6, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 0); // lw r0 then use r0: no stall
    vecs[9]  = mkv(1,  6, 0, 1, 0,  7, 1, 1, 0, 0, 3'b000, 2'b00, 2'b01, 1, 0); // rt from WB
    vecs[10] = mkv(1,  7, 7, 1, 1,  1, 1, 0, 1, 0, 3'b011, 2'b10, 2'b00, 1, 0); // branch over load-use
    vecs[11] = mkv(0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 1); // EX bubble after flush
    vecs[12] = mkv(1,  7, 0, 1, 1,  2, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 1);
    vecs[13] = mkv(1,  1, 1, 1, 1, 10, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 1);
    vecs[14] = mkv(1,  1, 1, 1, 1, 10, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 1);
    vecs[15] = mkv(1, 10, 2, 1, 1, 11, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 1);
    vecs[16] = mkv(0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 1, 1); // MEM beats WB

    // Reset state, with hostile inputs
    rst = 1'b0;
    set_id(1, 8, 8, 1, 1, 8, 1, 1);
    br_taken = 1'b1;
    cnt_clr  = 1'b0;
    #2;
    chk("rst_a_stall", 32'(a_stall), 32'd0);
    chk("rst_a_flush", 32'(a_flush), 32'd0);
    chk("rst_a_fwd",   32'({a_fa, a_fb}), 32'd0);
    chk("rst_a_cnt",   32'({a_sc, a_fe}), 32'd0);
    chk("rst_b_flush", 32'(b_flush), 32'd0);
    chk("rst_b_cnt",   32'({b_sc, b_fe}), 32'd0);
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br_taken = 1'b0;
    tick();

    // Table-driven run on the forwarding instance
    for (int i = 0; i < 17; i++) begin
      set_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
             vecs[i].dst, vecs[i].rw, vecs[i].mr);
      br_taken = vecs[i].br;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d_flush", i), 32'(a_flush), 32'(vecs[i].flush));
      chk($sformatf("v%0d_fwd_a", i), 32'(a_fa),    32'(vecs[i].fa));
      chk($sformatf("v%0d_fwd_b", i), 32'(a_fb),    32'(vecs[i].fb));
      chk($sformatf("v%0d_sc", i),    32'(a_sc),    32'(vecs[i].sc));
      chk($sformatf("v%0d_fe", i),    32'(a_fe),    32'(vecs[i].fe));
      tick();
    end

    // Stall-only mode: add r5 then or r6,r5,r1 gives two bubbles
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    #1; chk("so_c0_b_stall", 32'(b_stall), 32'd0);
    tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    #1; chk("so_c1_b_stall", 32'(b_stall), 32'd1);
    chk("so_c1_a_stall", 32'(a_stall), 32'd0);
    tick();
    #1; chk("so_c2_b_stall", 32'(b_stall), 32'd1);
    chk("so_c2_a_fwd_a", 32'(a_fa), 32'd2);
    tick();
    #1; chk("so_c3_b_stall", 32'(b_stall), 32'd0);
    chk("so_c3_b_sc", 32'(b_sc), 32'd2);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("so_c4_b_fwd", 32'({b_fa, b_fb}), 32'd0);
    chk("so_c4_b_stall", 32'(b_stall), 32'd0);
    tick();

    // Stall-only branch: BR_FLUSH=3 squashes MEM so the producer is gone
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    br_taken = 1'b1;
    #1; chk("br_b_stall", 32'(b_stall), 32'd0);
    chk("br_b_flush", 32'(b_flush), 32'h7);
    chk("br_a_flush", 32'(a_flush), 32'h3);
    tick();
    br_taken = 1'b0;
    #1; chk("br_b_mem_squashed", 32'(b_stall), 32'd0);
    chk("br_b_fe", 32'(b_fe), 32'd1);
    chk("br_b_flush_off", 32'(b_flush), 32'd0);
    tick();

    // Saturation: lw r8,0(r8) stalls every other cycle, ~300 stalls
    do_reset();
    set_id(1, 8, 0, 1, 0, 8, 1, 1);
    for (int k = 0; k < 600; k++) tick();
    chk("sat_sc", 32'(a_sc), 32'd255);
    chk("sat_fe", 32'(a_fe), 32'd0);

    // Clear wins over increment in a stalled cycle
    wait_a_stall("clr");
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1; chk("clr_sc", 32'(a_sc), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("post_clr_sc", 32'(a_sc), 32'd2);

    // Reset asserted mid-stall
    wait_a_stall("mid");
    chk("pre_rst_fwd_a", 32'(a_fa), 32'd1);
    rst = 1'b0;
    br_taken = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(a_stall), 32'd0);
    chk("mid_rst_flush", 32'(a_flush), 32'd0);
    chk("mid_rst_fwd",   32'({a_fa, a_fb}), 32'd0);
    chk("mid_rst_sc",    32'(a_sc), 32'd0);
    chk("mid_rst_b_sc",  32'(b_sc), 32'd0);
    rst = 1'b1;
    br_taken = 1'b0;
    tick();
    chk("rel_ex_loaded", 32'(a_stall), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, register-address width (legal 3..6).
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-003 SHALL have parameter BR_FLUSH, default 2, number of younger pipeline latches squashed on a taken branch (legal 1..3).
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width (legal 8..32).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 id_valid  in  1  ID-stage slot holds a real instruction.
REQ-009 id_rs, id_rt  in  RA_W each  ID-stage source register numbers.
REQ-010 id_use_rs, id_use_rt  in  1 each  the instruction reads rs / rt.
REQ-011 id_dst  in  RA_W  ID-stage destination register.
REQ-012 id_reg_write, id_mem_read  in  1 each  ID-stage instruction writes the register file / is a load.
REQ-013 br_taken  in  1  taken branch resolved this cycle.
REQ-014 cnt_clr  in  1  synchronous clear of both counters.
REQ-015 stall  out  1  hold PC and IF/ID; bubble into ID/EX.
REQ-016 flush_mask  out  3  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM squash.
REQ-017 fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
REQ-018 stall_cycles, flush_events  out  CNT_W each  saturating performance counters.

Function
REQ-019 SHALL keep an internal tracker of three slots (EX, MEM, WB), each holding valid, dst, reg_write, mem_read; the EX slot also holds rs, rt, use_rs, use_rt.
REQ-020 Every cycle SHALL advance WB<=MEM and MEM<=EX; EX loads the ID fields, or a bubble (valid=0) when stall=1 or flush_mask[1]=1.
REQ-021 When flush_mask[2]=1, MEM SHALL load a bubble instead of EX.
REQ-022 Producer match: slot valid & reg_write & dst!=0 & dst equals a used, non-zero ID source; register 0 never creates a hazard or a forward.
REQ-023 The register file is write-through, so a WB-slot producer SHALL never cause a stall.
REQ-024 FWD_EN=1: stall=1 only when id_valid and the EX slot is a matching load (load-use), giving exactly one bubble.
REQ-025 FWD_EN=0: stall=1 when id_valid and the EX or MEM slot matches, giving up to two bubbles.
REQ-026 stall and flush_mask SHALL be combinational from the tracker and the current inputs.
REQ-027 br_taken=1 SHALL force stall=0 and set flush_mask to the BR_FLUSH low bits: 001, 011 or 111.
REQ-028 flush_mask SHALL be 000 when br_taken=0.
REQ-029 fwd_a for EX rs: 10 if the MEM slot matches; otherwise 01 if the WB slot matches; otherwise 00. fwd_b is the same for rt.
REQ-030 If both MEM and WB match, the younger MEM slot SHALL win.
REQ-031 FWD_EN=0: fwd_a = fwd_b = 00 always.
REQ-032 stall_cycles SHALL increment on each cycle with stall=1; flush_events SHALL increment on each cycle with br_taken=1.
REQ-033 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-034 cnt_clr SHALL take priority over increment in the same cycle.

Reset
REQ-035 rst=0 SHALL immediately clear all tracker valid bits and both counters.
REQ-036 While rst=0, outputs SHALL be stall=0, flush_mask=000, fwd_a = fwd_b = 00, counters 0; this holds regardless of inputs.
REQ-037 Reset asserted mid-stall or mid-flush SHALL discard all in-flight tracker state; the first edge after release loads EX from the ID inputs.

Verification
REQ-038 FWD_EN=1, lw r8 followed by add r9,r8,r2: stall=1 for exactly 1 cycle. When add reaches EX, fwd_a=01, and stall_cycles=1.
REQ-039 FWD_EN=1, add r3 followed by sub r4,r3,r3: stall never asserts, and fwd_a = fwd_b = 10 when sub is in EX.
REQ-040 Producer writing r0, then a consumer of r0: stall=0 throughout and fwd_a=00.
REQ-041 FWD_EN=0, add r5 followed by or r6,r5,r1: stall=1 for 2 consecutive cycles, then fwd_a=00 (write-through path).
REQ-042 BR_FLUSH=2, br_taken coincident with a load-use condition: stall=0, flush_mask=011, the EX slot is a bubble next cycle, and flush_events increments by 1.
REQ-043 CNT_W=8, hold stall for 300 cycles: stall_cycles=255. Then pull rst low mid-stall: stall drops to 0 in the same cycle and counters read 0.
